guess_game_param: RTL and testbench
===================================

GUESS_GAME_PARAM -- requirements
Module: guess_game_param

Interface
REQ-001 SHALL provide parameter NDIG, default 4, number of active digits (1..4); digit positions at index NDIG..3 are unused.
REQ-002 SHALL provide parameter MAXD, default 9, largest legal digit value (1..9).
REQ-003 SHALL provide parameter MAX_TRIES, default 8, number of guesses allowed per round (1..15).
REQ-004 SHALL provide parameter WIN_MS, default 5000, number of cycles spent in CORRECT and in LOSE (1..65535).
REQ-005 SHALL provide parameter BLINK_MS, default 1000, LED blink half-period in cycles.
REQ-006 SHALL provide parameter WRAP, default 1, edit mode: 1 = wrap around, 0 = saturate.
REQ-007 SHALL provide parameter UNIQUE, default 0; 1 = reject an answer that contains repeated active digits.
REQ-008 SHALL have port myclk1000hz, input, 1 bit, system clock.
REQ-009 SHALL have port rst_1pulse, input, 1 bit, reset; rst_1pulse is asynchronous and active-high, and the clock is myclk1000hz.
REQ-010 SHALL have ports btn_r, btn_l, btn_u, btn_d, input, 1 bit each, single-cycle pulses that are already debounced.
REQ-011 SHALL have port LED, output, 16 bits, status LEDs.
REQ-012 SHALL have port DIGIT, output, 4 bits, active-low anode select.
REQ-013 SHALL have port DISPLAY, output, 7 bits, active-low segments.

Function
REQ-014 SHALL implement the states IDLE, SET, GUESS, WRONG, CORRECT and LOSE, plus a position index pos (NDIG-1 down to 0) and a 4-bit tries counter.
REQ-015 SHALL handle transitions as follows:
- IDLE with btn_r -> SET, pos=NDIG-1, answer=0.
- In SET or GUESS, btn_r with pos>0 -> pos-1.
- In SET or GUESS, btn_l with pos<NDIG-1 -> pos+1; btn_l with pos=NDIG-1 -> IDLE.
- If btn_r and btn_l arrive in the same cycle, btn_r wins.
REQ-016 SHALL, on btn_r in SET at pos=0, go to GUESS with pos=NDIG-1, guess=0 and tries=0; when UNIQUE=1 and any two active answer digits are equal, it SHALL instead stay in SET and set err.
REQ-017 SHALL, on btn_r in GUESS at pos=0, increment tries and then:
- go to CORRECT if A==NDIG;
- otherwise go to LOSE if the new tries==MAX_TRIES;
- otherwise go to WRONG.
REQ-018 SHALL, in WRONG, go to GUESS on btn_r (pos=NDIG-1, guess cleared to 0), and go to IDLE on btn_l.
REQ-019 SHALL leave CORRECT and LOSE for IDLE after exactly WIN_MS cycles in the state; the 16-bit timer clears on entry, and buttons are ignored in these states.
REQ-020 SHALL apply digit edits in SET (answer) and GUESS (guess) at position pos only:
- btn_d takes priority over btn_u.
- btn_u at MAXD -> 0 when WRAP=1, hold when WRAP=0.
- btn_d at 0 -> MAXD when WRAP=1, hold when WRAP=0.
- An edit and a btn_r in the same cycle both take effect.
REQ-021 SHALL clear err on any button pulse other than the one that sets it.
REQ-022 SHALL compute the scores combinationally:
- A = count of active i with answer[i]==guess[i].
- B = count of active pairs i!=j with answer[i]==guess[j].
- A and B are 4 bits wide; unused positions are excluded.
REQ-023 SHALL register the displayed nibbles (MSB first) one cycle after the state:
- IDLE: 4x dash (code 12).
- SET: answer; GUESS: guess; unused positions blank (code 15).
- WRONG and CORRECT: {A, 10, B, 11}.
- LOSE: answer.
REQ-024 SHALL register LED one cycle after the state:
- IDLE: 16'hF000.
- SET: bit 8+pos, with bit 15 = err.
- GUESS: bit 4+pos.
- WRONG: LED[3:0] = MAX_TRIES-tries.
- CORRECT: all on when (timer/BLINK_MS) is even, else all off.
- LOSE: 16'hAAAA when (timer/BLINK_MS) is even, else 16'h5555.
REQ-025 SHALL scan one digit per cycle in the order rightmost -> leftmost -> wrap, with DISPLAY matching DIGIT in the same cycle.
REQ-026 SHALL decode codes 0-9, 10 (A), 11 (b) and 12 (dash); any other code blanks the digit.

Reset
REQ-027 SHALL, while rst_1pulse=1 and independent of the clock, force state=IDLE, pos=NDIG-1, answer=0, guess=0, tries=0, timer=0 and err=0.
REQ-028 SHALL, under the same reset, force LED=16'hF000, display nibbles=16'hCCCC and DIGIT=4'b1110.
REQ-029 SHALL return to IDLE when reset is asserted mid-round, in any state, with no residual tries or err.

Structure
REQ-030 SHALL define the state encoding and the display codes (A=10, B=11, DASH=12, BLANK=15) in a shared package guess_game_pkg.
REQ-031 SHALL place the digit multiplexing and segment decode in one sub-module, seg7_scan (16-bit nibble input, DIGIT/DISPLAY outputs).

Verification
REQ-032 SHALL cover a default-parameter win: answer 1234, guess 1234 -> CORRECT with display 4A0b, LED toggling every 1000 cycles, and IDLE after 5000 cycles.
REQ-033 SHALL cover a wrong guess: answer 1234, guess 4321 -> WRONG with display 0A4b and LED[3:0]=7.
REQ-034 SHALL cover losing: MAX_TRIES=2, two wrong guesses -> LOSE with answer shown, LED 16'hAAAA/16'h5555, and IDLE after WIN_MS.
REQ-035 SHALL cover wrap and saturate: WRAP=1, btn_d at 0 -> 9 and btn_u at 9 -> 0; WRAP=0, btn_d at 0 -> 0.
REQ-036 SHALL cover uniqueness and width: UNIQUE=1 with answer 1123 then btn_r at pos 0 -> stays in SET with LED[15]=1; NDIG=2 -> two leftmost digits blank and A counts only 2 digits.
REQ-037 SHALL cover mid-round reset: reset asserted in GUESS with tries=3 -> immediate IDLE, LED 16'hF000, display dashes, tries=0.

Source files
------------

// File: rtl/guess_game_pkg.sv
// rtl/guess_game_pkg.sv - shared state encoding, display codes and scoring helpers
package guess_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_GUESS,
        S_WRONG,
        S_CORRECT,
        S_LOSE
    } state_t;

    localparam logic [3:0] CODE_A     = 4'd10;
    localparam logic [3:0] CODE_B     = 4'd11;
    localparam logic [3:0] CODE_DASH  = 4'd12;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Exact matches: same digit in the same active position.
    function automatic logic [3:0] score_a(input logic [15:0] ans, input logic [15:0] gs, input int ndig);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 4; i++)
            if (i < ndig && ans[4*i +: 4] == gs[4*i +: 4])
                cnt = cnt + 4'd1;
        return cnt;
    endfunction

    // Misplaced matches: answer digit found at a different active guess position.
    function automatic logic [3:0] score_b(input logic [15:0] ans, input logic [15:0] gs, input int ndig);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && i < ndig && j < ndig && ans[4*i +: 4] == gs[4*j +: 4])
                    cnt = cnt + 4'd1;
        return cnt;
    endfunction

    function automatic logic has_repeat(input logic [15:0] ans, input int ndig);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (i < ndig && j < ndig && ans[4*i +: 4] == ans[4*j +: 4])
                    r = 1'b1;
        return r;
    endfunction

    // Unused digit positions are shown blank.
    function automatic logic [15:0] mask_unused(input logic [15:0] v, input int ndig);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++)
            if (i >= ndig)
                r[4*i +: 4] = CODE_BLANK;
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed seven-segment scanner and decoder
module seg7_scan
    import guess_game_pkg::*;
(
    input  logic        myclk1000hz,
    input  logic        rst_1pulse,
    input  logic [15:0] nib,
    output logic [3:0]  DIGIT,
    output logic [6:0]  DISPLAY
);

    logic [1:0] sel;
    logic [3:0] code;

    // Advance the scan one digit per cycle, rightmost first.
    always_ff @(posedge myclk1000hz or posedge rst_1pulse) begin
        if (rst_1pulse)
            sel <= 2'd0;
        else
            sel <= sel + 2'd1;
    end

    // Anode select and segments derive from the same index so they always agree.
    always_comb begin
        DIGIT = ~(4'b0001 << sel);
        code  = nib[{sel, 2'b00} +: 4];
        case (code)
            4'd0:       DISPLAY = 7'b1000000;
            4'd1:       DISPLAY = 7'b1111001;
            4'd2:       DISPLAY = 7'b0100100;
            4'd3:       DISPLAY = 7'b0110000;
            4'd4:       DISPLAY = 7'b0011001;
            4'd5:       DISPLAY = 7'b0010010;
            4'd6:       DISPLAY = 7'b0000010;
            4'd7:       DISPLAY = 7'b1111000;
            4'd8:       DISPLAY = 7'b0000000;
            4'd9:       DISPLAY = 7'b0010000;
            CODE_A:     DISPLAY = 7'b0001000;
            CODE_B:     DISPLAY = 7'b0000011;
            CODE_DASH:  DISPLAY = 7'b0111111;
            default:    DISPLAY = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/guess_game_param.sv
// rtl/guess_game_param.sv - parameterised number guessing game with LED and 7-seg output
module guess_game_param
    import guess_game_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int MAXD      = 9,
    parameter int MAX_TRIES = 8,
    parameter int WIN_MS    = 5000,
    parameter int BLINK_MS  = 1000,
    parameter int WRAP      = 1,
    parameter int UNIQUE    = 0
) (
    input  logic        myclk1000hz,
    input  logic        rst_1pulse,
    input  logic        btn_r,
    input  logic        btn_l,
    input  logic        btn_u,
    input  logic        btn_d,
    output logic [15:0] LED,
    output logic [3:0]  DIGIT,
    output logic [6:0]  DISPLAY
);

    localparam logic [1:0]  TOP_POS  = 2'(NDIG - 1);
    localparam logic [3:0]  MAXD_V   = 4'(MAXD);
    localparam logic [3:0]  TRIES_V  = 4'(MAX_TRIES);
    localparam logic [15:0] WIN_LAST = 16'(WIN_MS - 1);
    localparam logic [15:0] BLINK_V  = 16'(BLINK_MS);

    state_t      state, state_n;
    logic [1:0]  pos, pos_n;
    logic [15:0] answer, answer_n, guess, guess_n, timer, timer_n;
    logic [3:0]  tries, tries_n;
    logic        err, err_n;
    logic [15:0] nib, nib_n, led_n, edit_src, edited;
    logic [3:0]  cur, upd, a_now, b_now;
    logic        blink_odd;

    // Game state registers.
    always_ff @(posedge myclk1000hz or posedge rst_1pulse) begin
        if (rst_1pulse) begin
            state  <= S_IDLE;
            pos    <= TOP_POS;
            answer <= '0;
            guess  <= '0;
            tries  <= '0;
            timer  <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            answer <= answer_n;
            guess  <= guess_n;
            tries  <= tries_n;
            timer  <= timer_n;
            err    <= err_n;
        end
    end

    // Digit edit at the cursor; down beats up, wrap or saturate at the ends.
    always_comb begin
        edit_src = (state == S_SET) ? answer : guess;
        cur      = edit_src[{pos, 2'b00} +: 4];
        upd      = cur;
        if (btn_d)
            upd = (cur == 4'd0) ? ((WRAP != 0) ? MAXD_V : 4'd0) : cur - 4'd1;
        else if (btn_u)
            upd = (cur == MAXD_V) ? ((WRAP != 0) ? 4'd0 : cur) : cur + 4'd1;
        edited = edit_src;
        edited[{pos, 2'b00} +: 4] = upd;
    end

    // Next-state logic; btn_r beats btn_l, edits land alongside btn_r.
    always_comb begin
        state_n  = state;
        pos_n    = pos;
        answer_n = answer;
        guess_n  = guess;
        tries_n  = tries;
        timer_n  = timer;
        err_n    = err;
        if (btn_r || btn_l || btn_u || btn_d)
            err_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (btn_r) begin
                    state_n  = S_SET;
                    pos_n    = TOP_POS;
                    answer_n = '0;
                end
            end
            S_SET, S_GUESS: begin
                if (state == S_SET)
                    answer_n = edited;
                else
                    guess_n = edited;
                if (btn_r) begin
                    if (pos != 2'd0) begin
                        pos_n = pos - 2'd1;
                    end else if (state == S_SET) begin
                        if (UNIQUE != 0 && has_repeat(edited, NDIG)) begin
                            err_n = 1'b1;
                        end else begin
                            state_n = S_GUESS;
                            pos_n   = TOP_POS;
                            guess_n = '0;
                            tries_n = '0;
                        end
                    end else begin
                        tries_n = tries + 4'd1;
                        pos_n   = TOP_POS;
                        timer_n = '0;
                        if (score_a(answer, edited, NDIG) == 4'(NDIG))
                            state_n = S_CORRECT;
                        else if (tries_n == TRIES_V)
                            state_n = S_LOSE;
                        else
                            state_n = S_WRONG;
                    end
                end else if (btn_l) begin
                    if (pos == TOP_POS)
                        state_n = S_IDLE;
                    else
                        pos_n = pos + 2'd1;
                end
            end
            S_WRONG: begin
                if (btn_r) begin
                    state_n = S_GUESS;
                    pos_n   = TOP_POS;
                    guess_n = '0;
                end else if (btn_l) begin
                    state_n = S_IDLE;
                end
            end
            S_CORRECT, S_LOSE: begin
                if (timer == WIN_LAST) begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Display nibbles and LED pattern derived from the current state.
    always_comb begin
        a_now     = score_a(answer, guess, NDIG);
        b_now     = score_b(answer, guess, NDIG);
        blink_odd = ((timer / BLINK_V) & 16'd1) != 16'd0;
        led_n     = 16'hF000;
        nib_n     = {4{CODE_DASH}};
        case (state)
            S_SET: begin
                led_n     = 16'h0100 << pos;
                led_n[15] = err;
                nib_n     = mask_unused(answer, NDIG);
            end
            S_GUESS: begin
                led_n = 16'h0010 << pos;
                nib_n = mask_unused(guess, NDIG);
            end
            S_WRONG: begin
                led_n = {12'h000, TRIES_V - tries};
                nib_n = {a_now, CODE_A, b_now, CODE_B};
            end
            S_CORRECT: begin
                led_n = blink_odd ? 16'h0000 : 16'hFFFF;
                nib_n = {a_now, CODE_A, b_now, CODE_B};
            end
            S_LOSE: begin
                led_n = blink_odd ? 16'h5555 : 16'hAAAA;
                nib_n = mask_unused(answer, NDIG);
            end
            default: ;
        endcase
    end

    // Outputs trail the state by one cycle.
    always_ff @(posedge myclk1000hz or posedge rst_1pulse) begin
        if (rst_1pulse) begin
            LED <= 16'hF000;
            nib <= 16'hCCCC;
        end else begin
            LED <= led_n;
            nib <= nib_n;
        end
    end

    seg7_scan u_scan (
        .myclk1000hz (myclk1000hz),
        .rst_1pulse  (rst_1pulse),
        .nib         (nib),
        .DIGIT       (DIGIT),
        .DISPLAY     (DISPLAY)
    );

endmodule

// File: tb/tb_guess_game_param.sv
// tb/tb_guess_game_param.sv - scoreboard bench for guess_game_param over three parameter sets
`timescale 1ns/1ps
module tb_guess_game_param;

    localparam int K_LED = 0, K_DISP = 1, K_TRIES = 2, K_DIGIT = 3;

    typedef struct packed {
        logic [1:0]  inst;
        logic [1:0]  kind;
        logic [15:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br[3], bl[3], bu[3], bd[3];
    logic [15:0] led_w[3];
    logic [3:0]  dig_w[3];
    logic [6:0]  dsp_w[3];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_chk = 0;
    int          m;
    item_t       sbq[$];
    string       nameq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    guess_game_param dut0 (
        .myclk1000hz(clk), .rst_1pulse(rst),
        .btn_r(br[0]), .btn_l(bl[0]), .btn_u(bu[0]), .btn_d(bd[0]),
        .LED(led_w[0]), .DIGIT(dig_w[0]), .DISPLAY(dsp_w[0]));

    guess_game_param #(.MAX_TRIES(2), .WIN_MS(300), .BLINK_MS(100), .WRAP(0), .UNIQUE(1)) dut1 (
        .myclk1000hz(clk), .rst_1pulse(rst),
        .btn_r(br[1]), .btn_l(bl[1]), .btn_u(bu[1]), .btn_d(bd[1]),
        .LED(led_w[1]), .DIGIT(dig_w[1]), .DISPLAY(dsp_w[1]));

    guess_game_param #(.NDIG(2)) dut2 (
        .myclk1000hz(clk), .rst_1pulse(rst),
        .btn_r(br[2]), .btn_l(bl[2]), .btn_u(bu[2]), .btn_d(bd[2]),
        .LED(led_w[2]), .DIGIT(dig_w[2]), .DISPLAY(dsp_w[2]));

    // Standard active-high gfedcba segment patterns, inverted for the active-low pins.
    function automatic logic [6:0] seg_exp(input logic [3:0] c);
        logic [6:0] hi;
        case (c)
            4'd0: hi = 7'h3F;  4'd1: hi = 7'h06;  4'd2: hi = 7'h5B;  4'd3: hi = 7'h4F;
            4'd4: hi = 7'h66;  4'd5: hi = 7'h6D;  4'd6: hi = 7'h7D;  4'd7: hi = 7'h07;
            4'd8: hi = 7'h7F;  4'd9: hi = 7'h6F;  4'd10: hi = 7'h77; 4'd11: hi = 7'h7C;
            4'd12: hi = 7'h40;
            default: hi = 7'h00;
        endcase
        return ~hi;
    endfunction

    function automatic logic [3:0] get_tries(input int inst);
        case (inst)
            0: return dut0.tries;
            1: return dut1.tries;
            default: return dut2.tries;
        endcase
    endfunction

    task automatic check_item(input item_t it, input string nm);
        logic [15:0] act, exp;
        int idx;
        idx = -1;
        case (dig_w[it.inst])
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
        endcase
        case (it.kind)
            2'(K_LED):   begin act = led_w[it.inst]; exp = it.exp; end
            2'(K_TRIES): begin act = {12'h0, get_tries(it.inst)}; exp = it.exp; end
            2'(K_DIGIT): begin act = {12'h0, dig_w[it.inst]}; exp = it.exp; end
            default: begin
                if (idx < 0) begin
                    act = {12'h0, dig_w[it.inst]};
                    exp = 16'hFFFF;
                end else begin
                    act = {9'h0, dsp_w[it.inst]};
                    exp = {9'h0, seg_exp(it.exp[4*idx +: 4])};
                end
            end
        endcase
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s inst%0d digit%0d: got %h expected %h", nm, it.inst, idx, act, exp);
    endtask

    // Monitor: one scoreboard entry is retired per cycle, away from the active edge.
    always @(negedge clk) begin : monitor
        item_t it;
        string nm;
        if (sbq.size() > 0) begin
            it = sbq.pop_front();
            nm = nameq.pop_front();
            check_item(it, nm);
        end
    end

    task automatic push(input int inst, input int kind, input logic [15:0] exp, input string nm);
        item_t it;
        it.inst = 2'(inst);
        it.kind = 2'(kind);
        it.exp  = exp;
        sbq.push_back(it);
        nameq.push_back(nm);
    endtask

    task automatic push_disp(input int inst, input logic [15:0] exp, input string nm);
        repeat (4) push(inst, K_DISP, exp, nm);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() > 0; i++) step(1);
        if (sbq.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
            sbq.delete();
            nameq.delete();
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    // b: 0=r 1=l 2=u 3=d; one-cycle pulse.
    task automatic press(input int inst, input int b);
        @(posedge clk); #1;
        case (b)
            0: br[inst] = 1'b1;
            1: bl[inst] = 1'b1;
            2: bu[inst] = 1'b1;
            default: bd[inst] = 1'b1;
        endcase
        @(posedge clk); #1;
        br[inst] = 1'b0; bl[inst] = 1'b0; bu[inst] = 1'b0; bd[inst] = 1'b0;
    endtask

    // Dial in each active digit from the left, pressing btn_r after each one.
    task automatic enter(input int inst, input logic [15:0] v, input int ndig);
        for (int p = ndig - 1; p >= 0; p--) begin
            repeat (int'(v[4*p +: 4])) press(inst, 2);
            press(inst, 0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        for (int i = 0; i < 3; i++) begin
            br[i] = 1'b0; bl[i] = 1'b0; bu[i] = 1'b0; bd[i] = 1'b0;
        end
        rst = 1'b1;
        step(3);
        for (int i = 0; i < 3; i++) begin
            push(i, K_LED, 16'hF000, "rst_led");
            push(i, K_DIGIT, 16'h000E, "rst_digit");
            push(i, K_TRIES, 16'h0000, "rst_tries");
            push_disp(i, 16'hCCCC, "rst_disp");
        end
        drain();
        rst = 1'b0;
        step(2);

        // Wrap edits and leaving SET from the leftmost digit.
        press(0, 0); step(1);
        push(0, K_LED, 16'h0800, "set_led");
        push_disp(0, 16'h0000, "set_disp");
        drain();
        press(0, 3); step(1);
        push_disp(0, 16'h9000, "wrap_down");
        drain();
        press(0, 2); step(1);
        push_disp(0, 16'h0000, "wrap_up");
        drain();
        press(0, 1); step(1);
        push(0, K_LED, 16'hF000, "left_exit");
        push_disp(0, 16'hCCCC, "left_exit_disp");
        drain();

        // Winning round with default parameters.
        press(0, 0);
        enter(0, 16'h1234, 4); step(1);
        push(0, K_LED, 16'h0080, "guess_led");
        push_disp(0, 16'h0000, "guess_disp");
        drain();
        enter(0, 16'h1234, 4);
        m = cyc;
        step(1);
        push(0, K_LED, 16'hFFFF, "win_led0");
        push_disp(0, 16'h4A0B, "win_disp");
        drain();
        wait_until(m + 1000); push(0, K_LED, 16'hFFFF, "win_blink999");
        wait_until(m + 1001); push(0, K_LED, 16'h0000, "win_blink1000");
        wait_until(m + 2001); push(0, K_LED, 16'hFFFF, "win_blink2000");
        wait_until(m + 5000); push(0, K_LED, 16'hFFFF, "win_last");
        wait_until(m + 5001); push(0, K_LED, 16'hF000, "win_idle");
        push_disp(0, 16'hCCCC, "win_idle_disp");
        drain();

        // Wrong guesses, then a reset in the middle of a round.
        press(0, 0);
        enter(0, 16'h1234, 4);
        enter(0, 16'h4321, 4); step(1);
        push(0, K_LED, 16'h0007, "wrong_led");
        push_disp(0, 16'h0A4B, "wrong_disp");
        drain();
        repeat (2) begin
            press(0, 0);
            enter(0, 16'h4321, 4);
        end
        step(1);
        push(0, K_LED, 16'h0005, "wrong3_led");
        drain();
        press(0, 0); step(1);
        push(0, K_TRIES, 16'h0003, "pre_rst_tries");
        push(0, K_LED, 16'h0080, "pre_rst_led");
        drain();
        rst = 1'b1;
        #1;
        push(0, K_LED, 16'hF000, "mid_rst_led");
        push(0, K_TRIES, 16'h0000, "mid_rst_tries");
        push(0, K_DIGIT, 16'h000E, "mid_rst_digit");
        push_disp(0, 16'hCCCC, "mid_rst_disp");
        drain();
        rst = 1'b0;
        step(2);

        // Saturating edit, uniqueness rejection, then losing with two tries.
        press(1, 0);
        press(1, 3); step(1);
        push_disp(1, 16'h0000, "sat_down");
        drain();
        enter(1, 16'h1123, 4); step(1);
        push(1, K_LED, 16'h8100, "uniq_err");
        push_disp(1, 16'h1123, "uniq_disp");
        drain();
        press(1, 2); step(1);
        push(1, K_LED, 16'h0100, "err_clear");
        push_disp(1, 16'h1124, "err_clear_disp");
        drain();
        repeat (3) press(1, 1);
        repeat (4) press(1, 2);
        repeat (4) press(1, 0);
        step(1);
        push(1, K_LED, 16'h0080, "uniq_ok");
        drain();
        repeat (4) press(1, 0);
        step(1);
        push(1, K_LED, 16'h0001, "lose_wrong_led");
        push_disp(1, 16'h0A0B, "lose_wrong_disp");
        drain();
        press(1, 0);
        repeat (4) press(1, 0);
        m = cyc;
        step(1);
        push(1, K_LED, 16'hAAAA, "lose_led0");
        push_disp(1, 16'h5124, "lose_disp");
        drain();
        wait_until(m + 101); push(1, K_LED, 16'h5555, "lose_blink");
        wait_until(m + 300); push(1, K_LED, 16'hAAAA, "lose_last");
        wait_until(m + 301); push(1, K_LED, 16'hF000, "lose_idle");
        drain();

        // Two-digit game: blank unused digits and score only active positions.
        press(2, 0);
        enter(2, 16'h0034, 2); step(1);
        push(2, K_LED, 16'h0020, "n2_guess_led");
        push_disp(2, 16'hFF00, "n2_guess_disp");
        drain();
        enter(2, 16'h0035, 2); step(1);
        push(2, K_LED, 16'h0007, "n2_wrong_led");
        push_disp(2, 16'h1A0B, "n2_score");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
